// File: rtl/ysyx_23060240_ctrl_pkg.sv
// Shared definitions for the execution sequencer: state encoding, default
// watchdog sizing and a helper that classifies the bus-wait states.
package ysyx_23060240_ctrl_pkg;

   // HALT and ERR share S_STOP. The sticky halted/bus_err flops tell them apart,
   // which keeps every state in 3 bits.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_IF_REQ  = 3'd1,
      S_IF_WAIT = 3'd2,
      S_EX      = 3'd3,
      S_LS_REQ  = 3'd4,
      S_LS_WAIT = 3'd5,
      S_WB      = 3'd6,
      S_STOP    = 3'd7
   } ctrl_state_e;

   localparam int TIMEOUT_W_DEF   = 8;
   localparam int TIMEOUT_MAX_DEF = 255;

   // States in which the controller waits on the IFU or the LSU. The watchdog runs only in these.
   function automatic logic is_bus_wait(input ctrl_state_e s);
      return (s == S_IF_REQ) || (s == S_IF_WAIT) || (s == S_LS_REQ) || (s == S_LS_WAIT);
   endfunction

endpackage

// File: rtl/ysyx_23060240_exec_ctrl_if.sv
// Handshake and decoder bundle between the sequencer (master) and the
// IFU/LSU/decoder side (slave).
interface ysyx_23060240_exec_ctrl_if;
   logic ifu_req_valid;
   logic ifu_req_ready;
   logic ifu_rsp_valid;
   logic ifu_rsp_ready;
   logic inst_we;
   logic dec_mem_rd_en;
   logic dec_mem_wr_en;
   logic dec_w_en;
   logic dec_trap;
   logic lsu_req_valid;
   logic lsu_req_ready;
   logic lsu_rsp_valid;
   logic pc_we;
   logic rf_we;
   logic halted;
   logic bus_err;

   modport master (
      output ifu_req_valid, ifu_rsp_ready, inst_we, lsu_req_valid,
             pc_we, rf_we, halted, bus_err,
      input  ifu_req_ready, ifu_rsp_valid, dec_mem_rd_en, dec_mem_wr_en,
             dec_w_en, dec_trap, lsu_req_ready, lsu_rsp_valid
   );

   modport slave (
      input  ifu_req_valid, ifu_rsp_ready, inst_we, lsu_req_valid,
             pc_we, rf_we, halted, bus_err,
      output ifu_req_ready, ifu_rsp_valid, dec_mem_rd_en, dec_mem_wr_en,
             dec_w_en, dec_trap, lsu_req_ready, lsu_rsp_valid
   );
endinterface

// File: rtl/ysyx_23060240_watchdog.sv
// Bus-wait watchdog. cnt_q holds the number of wait cycles already spent in
// the current state, so the current cycle is number cnt_q+1. expired is raised
// during the TIMEOUT_MAX-th consecutive wait cycle.
module ysyx_23060240_watchdog #(
   parameter int TIMEOUT_W   = 8,
   parameter int TIMEOUT_MAX = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'(TIMEOUT_MAX - 1);

   logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

   // Count wait cycles. A state change clears the count. The count saturates at LAST.
   always_comb begin
      cnt_d = cnt_q;
      if (clear)
         cnt_d = '0;
      else if (enable && (cnt_q != LAST))
         cnt_d = cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/ysyx_23060240_exec_ctrl.sv
// Multi-cycle sequencer: fetch -> execute -> [load/store] -> writeback.
// Sole source of the PC and register-file commit strobes.
// Optional feature macro: EXEC_CTRL_PERF_CNT_EN adds the perf_cycle and
// perf_instret 64-bit counters.
module ysyx_23060240_exec_ctrl
   import ysyx_23060240_ctrl_pkg::*;
#(
   parameter int TIMEOUT_W   = TIMEOUT_W_DEF,
   parameter int TIMEOUT_MAX = TIMEOUT_MAX_DEF
) (
   input  logic        clk,
   input  logic        rst,
`ifdef EXEC_CTRL_PERF_CNT_EN
   output logic [63:0] perf_cycle,
   output logic [63:0] perf_instret,
`endif
   ysyx_23060240_exec_ctrl_if.master bus
);

   ctrl_state_e state_q, state_d;
   logic ifu_req_valid_q, ifu_req_valid_d;
   logic ifu_rsp_ready_q, ifu_rsp_ready_d;
   logic lsu_req_valid_q, lsu_req_valid_d;
   logic pc_we_q, pc_we_d;
   logic halted_q, halted_d;
   logic bus_err_q, bus_err_d;
   logic wd_expired;

   ysyx_23060240_watchdog #(
      .TIMEOUT_W   (TIMEOUT_W),
      .TIMEOUT_MAX (TIMEOUT_MAX)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_d != state_q),
      .enable  (is_bus_wait(state_q)),
      .expired (wd_expired)
   );

   // Next-state logic. Each Moore output is decoded from the next state so it is registered.
   // A completed handshake is checked before the timeout, so it wins in the expiry cycle.
   always_comb begin
      state_d   = state_q;
      halted_d  = halted_q;
      bus_err_d = bus_err_q;
      case (state_q)
         S_IDLE:    state_d = S_IF_REQ;
         S_IF_REQ:
            if (bus.ifu_req_ready) state_d = S_IF_WAIT;
            else if (wd_expired) begin
               state_d   = S_STOP;
               bus_err_d = 1'b1;
            end
         S_IF_WAIT:
            if (bus.ifu_rsp_valid) state_d = S_EX;
            else if (wd_expired) begin
               state_d   = S_STOP;
               bus_err_d = 1'b1;
            end
         S_EX:
            if (bus.dec_trap) begin
               state_d  = S_STOP;
               halted_d = 1'b1;
            end
            else if (bus.dec_mem_rd_en || bus.dec_mem_wr_en) state_d = S_LS_REQ;
            else state_d = S_WB;
         S_LS_REQ:
            if (bus.lsu_req_ready) state_d = S_LS_WAIT;
            else if (wd_expired) begin
               state_d   = S_STOP;
               bus_err_d = 1'b1;
            end
         S_LS_WAIT:
            if (bus.lsu_rsp_valid) state_d = S_WB;
            else if (wd_expired) begin
               state_d   = S_STOP;
               bus_err_d = 1'b1;
            end
         S_WB:      state_d = S_IF_REQ;
         default:   state_d = S_STOP;
      endcase
      ifu_req_valid_d = (state_d == S_IF_REQ);
      ifu_rsp_ready_d = (state_d == S_IF_WAIT);
      lsu_req_valid_d = (state_d == S_LS_REQ);
      pc_we_d         = (state_d == S_WB);
   end

   // FSM state and registered outputs. Reset is asynchronous.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         ifu_req_valid_q <= 1'b0;
         ifu_rsp_ready_q <= 1'b0;
         lsu_req_valid_q <= 1'b0;
         pc_we_q         <= 1'b0;
         halted_q        <= 1'b0;
         bus_err_q       <= 1'b0;
      end
      else begin
         state_q         <= state_d;
         ifu_req_valid_q <= ifu_req_valid_d;
         ifu_rsp_ready_q <= ifu_rsp_ready_d;
         lsu_req_valid_q <= lsu_req_valid_d;
         pc_we_q         <= pc_we_d;
         halted_q        <= halted_d;
         bus_err_q       <= bus_err_d;
      end
   end

   // inst_we and rf_we gate a registered state strobe with a live input.
   // This lets them fire in the same cycle as the response or the WB decode.
   assign bus.ifu_req_valid = ifu_req_valid_q;
   assign bus.ifu_rsp_ready = ifu_rsp_ready_q;
   assign bus.inst_we       = ifu_rsp_ready_q & bus.ifu_rsp_valid;
   assign bus.lsu_req_valid = lsu_req_valid_q;
   assign bus.pc_we         = pc_we_q;
   assign bus.rf_we         = pc_we_q & bus.dec_w_en;
   assign bus.halted        = halted_q;
   assign bus.bus_err       = bus_err_q;

`ifdef EXEC_CTRL_PERF_CNT_EN
   logic [63:0] perf_cycle_q, perf_cycle_d;
   logic [63:0] perf_instret_q, perf_instret_d;

   // Cycle count covers every live state. Instret counts commit pulses.
   always_comb begin
      perf_cycle_d   = perf_cycle_q;
      perf_instret_d = perf_instret_q;
      if ((state_q != S_IDLE) && (state_q != S_STOP)) perf_cycle_d = perf_cycle_q + 64'd1;
      if (pc_we_q) perf_instret_d = perf_instret_q + 64'd1;
   end

   // Performance counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cycle_q   <= '0;
         perf_instret_q <= '0;
      end
      else begin
         perf_cycle_q   <= perf_cycle_d;
         perf_instret_q <= perf_instret_d;
      end
   end

   assign perf_cycle   = perf_cycle_q;
   assign perf_instret = perf_instret_q;
`endif

endmodule

// File: tb/tb_ysyx_23060240_exec_ctrl.sv
// Self-checking bench for ysyx_23060240_exec_ctrl.
// It applies a table of directed vectors first. It then runs randomized instruction
// timelines, where per-cycle expectations come from the chosen handshake delays.
// Directed trap, watchdog and reset sequences follow.
module tb_ysyx_23060240_exec_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ysyx_23060240_exec_ctrl_if bus_if();

`ifdef EXEC_CTRL_PERF_CNT_EN
   logic [63:0] perf_cycle, perf_instret;
`endif

   ysyx_23060240_exec_ctrl #(.TIMEOUT_W(8), .TIMEOUT_MAX(255)) dut (
      .clk          (clk),
      .rst          (rst),
`ifdef EXEC_CTRL_PERF_CNT_EN
      .perf_cycle   (perf_cycle),
      .perf_instret (perf_instret),
`endif
      .bus          (bus_if)
   );

   typedef struct packed {
      logic ifu_rdy, ifu_rsp, rd, wr, w_en, trap, lsu_rdy, lsu_rsp;
   } in_t;

   typedef struct {
      in_t        i;
      logic [7:0] e;
   } vec_t;

   localparam logic [7:0] I_IRDY = 8'h80, I_IRSP = 8'h40, I_RD = 8'h20, I_WR = 8'h10,
                          I_WEN = 8'h08, I_TRAP = 8'h04, I_LRDY = 8'h02, I_LRSP = 8'h01;
   localparam logic [7:0] O_IRQ = 8'h80, O_IRS = 8'h40, O_IWE = 8'h20, O_LRQ = 8'h10,
                          O_PC = 8'h08, O_RF = 8'h04, O_HLT = 8'h02, O_ERR = 8'h01;

   int total = 0;
   int bad   = 0;
   int act_n = 0;
   int pc_n  = 0;

   logic [7:0] obs;
   assign obs = {bus_if.ifu_req_valid, bus_if.ifu_rsp_ready, bus_if.inst_we, bus_if.lsu_req_valid,
                 bus_if.pc_we, bus_if.rf_we, bus_if.halted, bus_if.bus_err};

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input in_t i);
      bus_if.ifu_req_ready = i.ifu_rdy;
      bus_if.ifu_rsp_valid = i.ifu_rsp;
      bus_if.dec_mem_rd_en = i.rd;
      bus_if.dec_mem_wr_en = i.wr;
      bus_if.dec_w_en      = i.w_en;
      bus_if.dec_trap      = i.trap;
      bus_if.lsu_req_ready = i.lsu_rdy;
      bus_if.lsu_rsp_valid = i.lsu_rsp;
   endtask

   // Each step is one clock cycle. Inputs change on the falling edge and outputs are sampled 1 time unit later.
   task automatic step(input string name, input in_t i, input logic [7:0] e);
      @(negedge clk);
      drive(i);
      #1;
      check(name, obs, e);
`ifdef EXEC_CTRL_PERF_CNT_EN
      check64({name, "_perf_cycle"}, perf_cycle, 64'(act_n));
      check64({name, "_perf_instret"}, perf_instret, 64'(pc_n));
`endif
      if ((e & (O_HLT | O_ERR)) == 8'h00) act_n++;
      if ((e & O_PC) != 8'h00) pc_n++;
   endtask

   // Assert reset mid-cycle and check that the outputs clear without a clock edge.
   // Release on a falling edge, then check the single IDLE cycle.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check("reset_outs", obs, 8'h00);
`ifdef EXEC_CTRL_PERF_CNT_EN
      check64("reset_perf_cycle", perf_cycle, 64'd0);
      check64("reset_perf_instret", perf_instret, 64'd0);
`endif
      drive(in_t'(8'h00));
      @(negedge clk);
      @(negedge clk);
      rst   = 1'b0;
      act_n = 0;
      pc_n  = 0;
      #1;
      check("idle_cycle", obs, 8'h00);
   endtask

   function automatic in_t junk();
      return in_t'(8'($urandom_range(0, 255)));
   endfunction

   function automatic vec_t mk(input logic [7:0] i, input logic [7:0] e);
      vec_t v;
      v.i = in_t'(i);
      v.e = e;
      return v;
   endfunction

   // One instruction timeline. d1: cycles until ifu ready, d2: cycles until ifu response,
   // d3/d4: the same for the LSU. kind 0 = alu, 1 = load, 2 = store.
   // Inputs the controller must ignore carry random values.
   task automatic run_instr(input int d1, input int d2, input int kind, input logic w,
                            input int d3, input int d4);
      in_t i;
      for (int k = 0; k <= d1; k++) begin
         i = junk(); i.ifu_rdy = (k == d1);
         step("if_req", i, O_IRQ);
      end
      for (int k = 0; k <= d2; k++) begin
         i = junk(); i.ifu_rsp = (k == d2);
         step("if_wait", i, (k == d2) ? (O_IRS | O_IWE) : O_IRS);
      end
      i = junk(); i.trap = 1'b0; i.rd = (kind == 1); i.wr = (kind == 2);
      step("ex", i, 8'h00);
      if (kind != 0) begin
         for (int k = 0; k <= d3; k++) begin
            i = junk(); i.lsu_rdy = (k == d3);
            step("ls_req", i, O_LRQ);
         end
         for (int k = 0; k <= d4; k++) begin
            i = junk(); i.lsu_rsp = (k == d4);
            step("ls_wait", i, 8'h00);
         end
      end
      i = junk(); i.w_en = w;
      step("wb", i, w ? (O_PC | O_RF) : O_PC);
   endtask

   vec_t tbl[21];

   initial begin
      in_t i;
      // Cycle 2 onward after reset release: addi, load with a 3-cycle response delay,
      // then a store that sees simultaneous ready and response on both buses.
      tbl[0]  = mk(I_IRDY,          O_IRQ);
      tbl[1]  = mk(I_IRSP,          O_IRS | O_IWE);
      tbl[2]  = mk(I_WEN,           8'h00);
      tbl[3]  = mk(I_WEN,           O_PC | O_RF);
      tbl[4]  = mk(I_IRDY,          O_IRQ);
      tbl[5]  = mk(I_IRSP,          O_IRS | O_IWE);
      tbl[6]  = mk(I_RD | I_WEN,    8'h00);
      tbl[7]  = mk(I_LRDY,          O_LRQ);
      tbl[8]  = mk(8'h00,           8'h00);
      tbl[9]  = mk(8'h00,           8'h00);
      tbl[10] = mk(8'h00,           8'h00);
      tbl[11] = mk(I_LRSP,          8'h00);
      tbl[12] = mk(I_WEN,           O_PC | O_RF);
      tbl[13] = mk(I_IRDY | I_IRSP, O_IRQ);
      tbl[14] = mk(8'h00,           O_IRS);
      tbl[15] = mk(I_IRSP,          O_IRS | O_IWE);
      tbl[16] = mk(I_WR,            8'h00);
      tbl[17] = mk(I_LRDY | I_LRSP, O_LRQ);
      tbl[18] = mk(I_LRSP,          8'h00);
      tbl[19] = mk(8'h00,           O_PC);
      tbl[20] = mk(8'h00,           O_IRQ);

      drive(in_t'(8'h00));
      do_reset();
      for (int n = 0; n < 21; n++) step($sformatf("vec%0d", n), tbl[n].i, tbl[n].e);

      // Random instruction mix. The table left the controller in IF_REQ.
      for (int n = 0; n < 60; n++)
         run_instr($urandom_range(0, 6), $urandom_range(0, 6), $urandom_range(0, 2),
                   1'($urandom_range(0, 1)), $urandom_range(0, 6), $urandom_range(0, 6));

      // Fetch ready held low for 10 cycles.
      do_reset();
      run_instr(10, 0, 0, 1'b1, 0, 0);
      run_instr(0, 0, 0, 1'b0, 0, 0);

      // Trap with a load also decoded. Trap takes priority, so the controller halts for good.
      do_reset();
      step("trap_if_req", in_t'(I_IRDY), O_IRQ);
      step("trap_if_wait", in_t'(I_IRSP), O_IRS | O_IWE);
      step("trap_ex", in_t'(I_TRAP | I_RD | I_WEN), 8'h00);
      for (int k = 0; k < 20; k++) step("halt_hold", junk(), O_HLT);

      // Fetch response never arrives. The controller enters ERR after 255 wait cycles.
      do_reset();
      step("to_if_req", in_t'(I_IRDY), O_IRQ);
      for (int k = 0; k < 255; k++) step("to_if_wait", in_t'(8'h00), O_IRS);
      for (int k = 0; k < 5; k++) begin
         i = junk();
         step("to_err_hold", i, O_ERR);
      end

      // Response lands in the expiry cycle. The handshake wins over the timeout.
      do_reset();
      step("edge_if_req", in_t'(I_IRDY), O_IRQ);
      for (int k = 0; k < 254; k++) step("edge_if_wait", in_t'(8'h00), O_IRS);
      step("edge_rsp", in_t'(I_IRSP), O_IRS | O_IWE);
      step("edge_ex", in_t'(8'h00), 8'h00);
      step("edge_wb", in_t'(8'h00), O_PC);
      step("edge_next", in_t'(8'h00), O_IRQ);

      // LSU request never accepted. The controller enters ERR.
      do_reset();
      step("lto_if_req", in_t'(I_IRDY), O_IRQ);
      step("lto_if_wait", in_t'(I_IRSP), O_IRS | O_IWE);
      step("lto_ex", in_t'(I_WR), 8'h00);
      for (int k = 0; k < 255; k++) step("lto_ls_req", in_t'(8'h00), O_LRQ);
      step("lto_err", in_t'(8'h00), O_ERR);

      // Reset asserted while ifu_req_valid is high. The output must drop with no clock edge.
      do_reset();
      step("arst_if_req", in_t'(8'h00), O_IRQ);
      do_reset();

      // Reset asserted in the middle of LS_WAIT, followed by a fresh fetch.
      run_instr(0, 0, 0, 1'b1, 0, 0);
      step("ls_if_req", in_t'(I_IRDY), O_IRQ);
      step("ls_if_wait", in_t'(I_IRSP), O_IRS | O_IWE);
      step("ls_ex", in_t'(I_RD), 8'h00);
      step("ls_req", in_t'(I_LRDY), O_LRQ);
      step("ls_wait0", in_t'(8'h00), 8'h00);
      step("ls_wait1", in_t'(8'h00), 8'h00);
      do_reset();
      step("post_rst_if_req", in_t'(I_IRDY), O_IRQ);
      step("post_rst_if_wait", in_t'(I_IRSP), O_IRS | O_IWE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
